// File: rtl/exp_adjust_pipe.sv
// rtl/exp_adjust_pipe.sv - two-stage elastic exponent adjuster (pass/+1/+amt/-amt), optional EXP_ADJ_SATURATE_EN clamping
module exp_adjust_pipe #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_exp,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_exp,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_zero
);

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_exp_q, s1_exp_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [WIDTH:0]   s1_amt_q, s1_amt_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_exp_q, s2_exp_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_unf_q, s2_unf_d;
    logic             s2_zero_q, s2_zero_d;

    logic             s2_load;
    logic             s1_move;
    logic             accept;

    logic [WIDTH:0]   exp_ext;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic             unf_c;

    // S2 may take new data when empty or when its result leaves this cycle
    assign s2_load  = !s2_v_q || out_ready;
    assign s1_move  = s1_v_q && s2_load;
    assign in_ready = !s1_v_q || s1_move;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_exp_d = s1_exp_q;
        s1_op_d  = s1_op_q;
        s1_amt_d = s1_amt_q;
        if (in_ready) begin
            s1_v_d = in_valid;
        end
        if (accept) begin
            s1_exp_d = in_exp;
            s1_op_d  = in_op;
            s1_amt_d = {{(WIDTH+1-AMT_W){1'b0}}, in_amt};
        end
    end

    // Bit WIDTH of the widened result is the carry for additions and the borrow for subtraction
    always_comb begin
        exp_ext = {1'b0, s1_exp_q};
        sum_c   = exp_ext;
        case (s1_op_q)
            OP_PASS: sum_c = exp_ext;
            OP_INC:  sum_c = exp_ext + (WIDTH+1)'(1);
            OP_SUB:  sum_c = exp_ext - s1_amt_q;
            OP_ADD:  sum_c = exp_ext + s1_amt_q;
            default: sum_c = exp_ext;
        endcase
        ovf_c = ((s1_op_q == OP_INC) || (s1_op_q == OP_ADD)) && sum_c[WIDTH];
        unf_c = (s1_op_q == OP_SUB) && sum_c[WIDTH];
        res_c = sum_c[WIDTH-1:0];
`ifdef EXP_ADJ_SATURATE_EN
        if (ovf_c) begin
            res_c = {WIDTH{1'b1}};
        end
        if (unf_c) begin
            res_c = '0;
        end
`endif
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_exp_d  = s2_exp_q;
        s2_ovf_d  = s2_ovf_q;
        s2_unf_d  = s2_unf_q;
        s2_zero_d = s2_zero_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
        end
        if (s1_move) begin
            s2_exp_d  = res_c;
            s2_ovf_d  = ovf_c;
            s2_unf_d  = unf_c;
            s2_zero_d = (res_c == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_exp_q  <= '0;
            s1_op_q   <= OP_PASS;
            s1_amt_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_exp_q  <= '0;
            s2_ovf_q  <= 1'b0;
            s2_unf_q  <= 1'b0;
            s2_zero_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_exp_q  <= s1_exp_d;
            s1_op_q   <= s1_op_d;
            s1_amt_q  <= s1_amt_d;
            s2_v_q    <= s2_v_d;
            s2_exp_q  <= s2_exp_d;
            s2_ovf_q  <= s2_ovf_d;
            s2_unf_q  <= s2_unf_d;
            s2_zero_q <= s2_zero_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_exp   = s2_exp_q;
    assign out_ovf   = s2_ovf_q;
    assign out_unf   = s2_unf_q;
    assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// tb/tb_exp_adjust_pipe.sv - scoreboard bench for exp_adjust_pipe (WIDTH=8, AMT_W=5)
module tb_exp_adjust_pipe;

    typedef struct {
        logic [7:0] e;
        logic [1:0] op;
        logic [4:0] amt;
        logic [7:0] re;
        logic       ovf;
        logic       unf;
        logic       z;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_exp = '0;
    logic [1:0] in_op = '0;
    logic [4:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_exp;
    logic       out_ovf, out_unf, out_zero;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_pop = 0;
    int         pop_cyc[128];
    int         stalls = 0;
    bit         rand_rdy = 1'b0;
    logic [10:0] sb[$];
    vec_t       vt[20];

    exp_adjust_pipe #(.WIDTH(8), .AMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] expect_of(vec_t v);
        logic [7:0] r = v.re;
        logic       z = v.z;
`ifdef EXP_ADJ_SATURATE_EN
        if (v.ovf) begin r = 8'hFF; z = 1'b0; end
        if (v.unf) begin r = 8'h00; z = 1'b1; end
`endif
        return {r, v.ovf, v.unf, z};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic drive(vec_t v);
        bit acc = 1'b0;
        int t = 0;
        in_valid = 1'b1;
        in_exp   = v.e;
        in_op    = v.op;
        in_amt   = v.amt;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            t++;
        end
        if (acc) sb.push_back(expect_of(v));
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    // Monitor: pops on each transfer and checks that stalled outputs hold
    initial begin
        logic        held_v = 1'b0;
        logic [10:0] held = '0;
        logic [10:0] cur;
        logic [10:0] exp_v;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {out_exp, out_ovf, out_unf, out_zero};
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) check("stall_hold", {out_valid, cur}, {1'b1, held});
                held_v = out_valid && !out_ready;
                held = cur;
                if (out_valid && out_ready) begin
                    if (n_pop < 128) pop_cyc[n_pop] = cyc;
                    n_pop++;
                    if (sb.size() == 0) begin
                        check("unexpected_out", {21'd0, cur}, 32'hFFFFFFFF);
                    end else begin
                        exp_v = sb.pop_front();
                        check("result", {21'd0, cur}, {21'd0, exp_v});
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int base;
        int npop0;
        vt[0]  = '{8'h7F, 2'b01, 5'h00, 8'h80, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{8'hFF, 2'b01, 5'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{8'h05, 2'b10, 5'h07, 8'hFE, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{8'h10, 2'b10, 5'h10, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{8'h00, 2'b10, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{8'h3C, 2'b00, 5'h1F, 8'h3C, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{8'h20, 2'b11, 5'h00, 8'h20, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{8'hF0, 2'b11, 5'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{8'hF0, 2'b11, 5'h10, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{8'hFE, 2'b11, 5'h1F, 8'h1D, 1'b1, 1'b0, 1'b0};
        vt[10] = '{8'h00, 2'b00, 5'h05, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[11] = '{8'h80, 2'b10, 5'h1F, 8'h61, 1'b0, 1'b0, 1'b0};
        vt[12] = '{8'h00, 2'b10, 5'h01, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[13] = '{8'h1F, 2'b10, 5'h1F, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[14] = '{8'hFE, 2'b01, 5'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[15] = '{8'h01, 2'b10, 5'h02, 8'hFF, 1'b0, 1'b1, 1'b0};
        vt[16] = '{8'h55, 2'b11, 5'h0A, 8'h5F, 1'b0, 1'b0, 1'b0};
        vt[17] = '{8'hAA, 2'b10, 5'h0A, 8'hA0, 1'b0, 1'b0, 1'b0};
        vt[18] = '{8'hFF, 2'b00, 5'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[19] = '{8'h00, 2'b01, 5'h00, 8'h01, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bus", {out_exp, out_ovf, out_unf, out_zero}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_rel", out_valid, 0);

        // Two-cycle latency, exp=0x7F +1
        @(posedge clk);
        #1 out_ready = 1'b1;
        drive(vt[0]);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_c1", out_valid, 0);
        @(negedge clk);
        check("latency_c2", out_valid, 1);
        drain();

        // Back-to-back with out_ready held high: no stalls, one result per cycle
        @(posedge clk);
        #1;
        stalls = 0;
        base = n_pop;
        for (int i = 0; i < 20; i++) drive(vt[i]);
        in_valid = 1'b0;
        drain();
        check("tput_stalls", stalls, 0);
        check("tput_pops", n_pop - base, 20);
        check("tput_span", pop_cyc[base + 19] - pop_cyc[base], 19);

        // Same vectors with randomly toggled out_ready
        rand_rdy = 1'b1;
        @(posedge clk);
        #1;
        base = n_pop;
        for (int i = 0; i < 20; i++) drive(vt[19 - i]);
        in_valid = 1'b0;
        drain();
        check("rand_pops", n_pop - base, 20);
        rand_rdy = 1'b0;

        // Reset mid-stream with two transactions in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(vt[7]);
        drive(vt[8]);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_exp", out_exp, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        npop0 = n_pop;
        repeat (6) @(negedge clk);
        check("midrst_no_stale", n_pop - npop0, 0);
        check("midrst_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
